// File: rtl/hack_pkg.sv
// Shared Hack platform definitions: word width, KBD register address, keyboard FSM states.
package hack_pkg;
   localparam int          HACK_WORD_W = 16;
   localparam logic [15:0] KBD_ADDR    = 16'h6000;

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      GAP
   } kbd_state_t;
endpackage

// File: rtl/hack_sync_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers and an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module hack_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wr_data,
   output logic [W-1:0]           rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == (AW + 1)'(DEPTH));
   assign empty   = (count == '0);
endmodule

// File: rtl/hack_kbd_fifo.sv
// Keyboard stage feeding the Hack KBD register: buffers key codes, shows the oldest,
// and forces a zero gap after each ack. Define HACK_KBD_OVF_CNT_EN to add drop_cnt.
module hack_kbd_fifo
   import hack_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int GAP_CYCLES = 4,
   parameter int CODE_W     = HACK_WORD_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [CODE_W-1:0]      in_code,
   input  logic                   kbd_ack,
   output logic [CODE_W-1:0]      kbd_out,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   overflow
`ifdef HACK_KBD_OVF_CNT_EN
   ,output logic [7:0]            drop_cnt
`endif
);
   localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

   kbd_state_t        state, state_n;
   logic [7:0]        gap_cnt, gap_n;
   logic [CODE_W-1:0] kbd_out_n;
   logic [CODE_W-1:0] rd_data;
   logic              empty;
   logic              push_req;
   logic              pop;
   logic              drop;

   assign push_req = in_valid && (in_code != '0);
   assign drop     = push_req && full && !pop;

   hack_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (CODE_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_req),
      .pop     (pop),
      .wr_data (in_code),
      .rd_data (rd_data),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      state_n   = state;
      gap_n     = gap_cnt;
      kbd_out_n = kbd_out;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            kbd_out_n = '0;
            if (!empty) begin
               state_n   = SHOW;
               kbd_out_n = rd_data;
            end
         end
         SHOW: begin
            if (kbd_ack) begin
               pop       = 1'b1;
               gap_n     = GAP_LOAD;
               kbd_out_n = '0;
               state_n   = GAP;
            end
         end
         GAP: begin
            kbd_out_n = '0;
            // Leave on the decrement to zero so the output is 0 for exactly GAP_CYCLES cycles.
            if (gap_cnt <= 8'd1) begin
               gap_n = '0;
               if (!empty) begin
                  state_n   = SHOW;
                  kbd_out_n = rd_data;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               gap_n = gap_cnt - 8'd1;
            end
         end
         default: begin
            state_n   = IDLE;
            kbd_out_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         gap_cnt  <= '0;
         kbd_out  <= '0;
         overflow <= 1'b0;
      end else begin
         state   <= state_n;
         gap_cnt <= gap_n;
         kbd_out <= kbd_out_n;
         if (drop) overflow <= 1'b1;
      end
   end

`ifdef HACK_KBD_OVF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)                        drop_cnt <= '0;
      else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_hack_kbd_fifo.sv
// Scoreboard bench for hack_kbd_fifo: accepted codes are queued on push and
// compared against kbd_out when acknowledged; gaps, flags and reset are checked directly.
module tb_hack_kbd_fifo;
   localparam int DEPTH  = 8;
   localparam int GAP    = 4;
   localparam int CODE_W = 16;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   in_valid = 1'b0;
   logic [CODE_W-1:0]      in_code = '0;
   logic                   kbd_ack = 1'b0;
   logic [CODE_W-1:0]      kbd_out;
   logic [$clog2(DEPTH):0] count;
   logic                   full;
   logic                   overflow;
`ifdef HACK_KBD_OVF_CNT_EN
   logic [7:0]             drop_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [CODE_W-1:0] q[$];
   logic              m_ovf = 1'b0;
   int                m_drops = 0;

   hack_kbd_fifo #(
      .DEPTH      (DEPTH),
      .GAP_CYCLES (GAP),
      .CODE_W     (CODE_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_code  (in_code),
      .kbd_ack  (kbd_ack),
      .kbd_out  (kbd_out),
      .count    (count),
      .full     (full),
      .overflow (overflow)
`ifdef HACK_KBD_OVF_CNT_EN
      ,.drop_cnt (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Bench model of a push with no simultaneous ack.
   task automatic push(input logic [CODE_W-1:0] code);
      in_valid = 1'b1;
      in_code  = code;
      tick();
      in_valid = 1'b0;
      in_code  = '0;
      if (code != '0) begin
         if (q.size() < DEPTH) q.push_back(code);
         else begin
            m_ovf = 1'b1;
            m_drops++;
         end
      end
      check("push_count", 32'(count), 32'(q.size()));
      check("push_full", 32'(full), 32'(q.size() == DEPTH));
      check("push_ovf", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic wait_show();
      int n = 0;
      while (kbd_out == '0 && n < 20) begin
         tick();
         n++;
      end
      check("show_seen", 32'(kbd_out != '0), 32'd1);
   endtask

   // Ack the shown code (optionally with a simultaneous push) and verify the gap.
   task automatic do_ack(input logic with_push, input logic [CODE_W-1:0] code);
      logic [CODE_W-1:0] exp_code;
      exp_code = (q.size() > 0) ? q.pop_front() : '0;
      check("ack_code", 32'(kbd_out), 32'(exp_code));
      if (with_push && code != '0) q.push_back(code);
      kbd_ack  = 1'b1;
      in_valid = with_push;
      in_code  = code;
      tick();
      kbd_ack  = 1'b0;
      in_valid = 1'b0;
      in_code  = '0;
      check("ack_count", 32'(count), 32'(q.size()));
      check("ack_ovf", 32'(overflow), 32'(m_ovf));
      for (int i = 0; i < GAP; i++) begin
         check("gap_zero", 32'(kbd_out), 32'd0);
         tick();
      end
      check("after_gap", 32'(kbd_out), 32'((q.size() > 0) ? q[0] : '0));
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      repeat (5) tick();
      check("rst_kbd_out", 32'(kbd_out), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      // Zero code is ignored.
      push(16'h0000);
      check("zero_ignored", 32'(kbd_out), 32'd0);

      // Single key latency and gap.
      push(16'h0041);
      check("lat_t1", 32'(kbd_out), 32'd0);
      tick();
      check("lat_t2", 32'(kbd_out), 32'h41);
      do_ack(1'b0, '0);
      repeat (3) tick();
      check("idle_stays_zero", 32'(kbd_out), 32'd0);

      // Back-to-back keys.
      push(16'h0041);
      push(16'h0042);
      push(16'h0043);
      for (int k = 0; k < 3; k++) begin
         wait_show();
         do_ack(1'b0, '0);
      end
      check("b2b_empty", 32'(count), 32'd0);

      // Fill, simultaneous push+ack while full, then one dropped push.
      for (int k = 0; k < DEPTH; k++) push(CODE_W'(16'h0061 + k));
      wait_show();
      do_ack(1'b1, 16'h007A);
      check("simul_full", 32'(full), 32'd1);
      push(16'h007B);
      check("drop_ovf", 32'(overflow), 32'd1);
`ifdef HACK_KBD_OVF_CNT_EN
      check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
      while (q.size() > 0) begin
         wait_show();
         do_ack(1'b0, '0);
      end
      check("drain_count", 32'(count), 32'd0);

      // Reset in the middle of a gap with entries stored.
      for (int k = 0; k < 4; k++) push(CODE_W'(16'h0031 + k));
      wait_show();
      kbd_ack = 1'b1;
      tick();
      kbd_ack = 1'b0;
      tick();
      check("mid_gap_count", 32'(count), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      m_drops = 0;
      check("rst2_kbd_out", 32'(kbd_out), 32'd0);
      check("rst2_count", 32'(count), 32'd0);
      check("rst2_ovf", 32'(overflow), 32'd0);
      tick();
      check("rst2_idle", 32'(kbd_out), 32'd0);
      push(16'h0020);
      check("post_rst_t1", 32'(kbd_out), 32'd0);
      tick();
      check("post_rst_t2", 32'(kbd_out), 32'h20);
      do_ack(1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
